// File: rtl/cu_loopback_selftest.sv
// rtl/cu_loopback_selftest.sv - walking-1/walking-0 loopback self-test sequencer
//
// Purpose:
//   Drives walking-1 then walking-0 patterns onto WIDTH leg pins and checks
//   each one back through an external loopback. A cycle watchdog bounds the
//   run. The result is reported as pass, fail or timeout.
//
// Optional feature macro: SELFTEST_UART_EN
//   When defined, one status byte ('P', 'F' or 'T') is sent as 8N1 on uart_tx
//   each time a result state is entered. When undefined, uart_tx is tied high.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   one-cycle pulse, accepted only when not busy
//   hold       in   freezes the settle counter while in DRIVE
//   leg_in     in   looped-back pins, asynchronous to clk
//   leg_out    out  pattern drive
//   leg_oe     out  high while a run is active
//   busy       out  high from start acceptance until a result state
//   done       out  high in PASS, FAIL or TOUT
//   pass       out  high only in PASS
//   fail_idx   out  pattern index of the first mismatch
//   fail_data  out  synchronised leg_in captured at the first mismatch
//   uart_tx    out  status serial line, idle high
module cu_loopback_selftest #(
  parameter int WIDTH          = 8,
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int CLK_HZ         = 100000000,
  parameter int BAUD           = 1000000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       hold,
  input  logic [WIDTH-1:0]           leg_in,
  output logic [WIDTH-1:0]           leg_out,
  output logic                       leg_oe,
  output logic                       busy,
  output logic                       done,
  output logic                       pass,
  output logic [$clog2(2*WIDTH)-1:0] fail_idx,
  output logic [WIDTH-1:0]           fail_data,
  output logic                       uart_tx
);

  localparam int NPAT  = 2 * WIDTH;
  localparam int IDX_W = $clog2(NPAT);
  localparam int SET_W = $clog2(SETTLE_CYCLES);
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NPAT - 1);
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_DRIVE, S_CHECK, S_PASS, S_FAIL, S_TOUT
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [SET_W-1:0]   settle_q, settle_d;
  logic [WD_W-1:0]    wdog_q, wdog_d;
  logic [IDX_W-1:0]   fail_idx_q, fail_idx_d;
  logic [WIDTH-1:0]   fail_data_q, fail_data_d;
  logic [WIDTH-1:0]   leg_meta_q, leg_meta_d;
  logic [WIDTH-1:0]   leg_sync_q, leg_sync_d;
  logic               busy_w;

  // Indices below WIDTH walk a one, the upper half walks a zero.
  function automatic logic [WIDTH-1:0] pattern(input logic [IDX_W-1:0] k);
    logic [WIDTH-1:0] one_hot;
    if (k < IDX_W'(WIDTH)) begin
      one_hot = WIDTH'(1) << k;
      pattern = one_hot;
    end else begin
      one_hot = WIDTH'(1) << (k - IDX_W'(WIDTH));
      pattern = ~one_hot;
    end
  endfunction

  assign busy_w = (state_q == S_DRIVE) || (state_q == S_CHECK);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      settle_q    <= '0;
      wdog_q      <= '0;
      fail_idx_q  <= '0;
      fail_data_q <= '0;
      leg_meta_q  <= '0;
      leg_sync_q  <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      settle_q    <= settle_d;
      wdog_q      <= wdog_d;
      fail_idx_q  <= fail_idx_d;
      fail_data_q <= fail_data_d;
      leg_meta_q  <= leg_meta_d;
      leg_sync_q  <= leg_sync_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    settle_d    = settle_q;
    wdog_d      = wdog_q;
    fail_idx_d  = fail_idx_q;
    fail_data_d = fail_data_q;
    leg_meta_d  = leg_in;
    leg_sync_d  = leg_meta_q;

    // Watchdog saturates on its last count, so it can never wrap.
    if (busy_w && (wdog_q != WD_LAST)) begin
      wdog_d = wdog_q + WD_W'(1);
    end

    // Timeout is tested first so it overrides a CHECK verdict on the same cycle.
    if (busy_w && (wdog_q == WD_LAST)) begin
      state_d = S_TOUT;
    end else begin
      case (state_q)
        S_DRIVE: begin
          if (!hold) begin
            if (settle_q == SET_LAST) begin
              settle_d = '0;
              state_d  = S_CHECK;
            end else begin
              settle_d = settle_q + SET_W'(1);
            end
          end
        end
        S_CHECK: begin
          if (leg_sync_q != pattern(idx_q)) begin
            state_d     = S_FAIL;
            fail_idx_d  = idx_q;
            fail_data_d = leg_sync_q;
          end else if (idx_q == LAST_IDX) begin
            state_d = S_PASS;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = S_DRIVE;
          end
        end
        default: begin
          // IDLE and the three result states all accept a fresh run.
          if (start) begin
            state_d     = S_DRIVE;
            idx_d       = '0;
            settle_d    = '0;
            wdog_d      = '0;
            fail_idx_d  = '0;
            fail_data_d = '0;
          end
        end
      endcase
    end
  end

  // Output logic
  always_comb begin
    busy      = busy_w;
    leg_oe    = busy_w;
    leg_out   = busy_w ? pattern(idx_q) : '0;
    done      = (state_q == S_PASS) || (state_q == S_FAIL) || (state_q == S_TOUT);
    pass      = (state_q == S_PASS);
    fail_idx  = fail_idx_q;
    fail_data = fail_data_q;
  end

`ifdef SELFTEST_UART_EN
  localparam int BIT_CYC = (CLK_HZ / BAUD < 1) ? 1 : CLK_HZ / BAUD;
  localparam int BAUD_W  = $clog2(BIT_CYC + 1);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BIT_CYC - 1);

  logic [9:0]        tx_shift_q, tx_shift_d;
  logic [3:0]        tx_bits_q, tx_bits_d;
  logic [BAUD_W-1:0] tx_baud_q, tx_baud_d;
  logic              result_entry;
  logic [7:0]        tx_byte;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_shift_q <= '1;
      tx_bits_q  <= '0;
      tx_baud_q  <= '0;
    end else begin
      tx_shift_q <= tx_shift_d;
      tx_bits_q  <= tx_bits_d;
      tx_baud_q  <= tx_baud_d;
    end
  end

  // A frame in flight always completes; a result entered meanwhile is not sent.
  always_comb begin
    result_entry = busy_w &&
                   ((state_d == S_PASS) || (state_d == S_FAIL) || (state_d == S_TOUT));
    tx_byte      = (state_d == S_PASS) ? 8'h50 : (state_d == S_FAIL) ? 8'h46 : 8'h54;
    tx_shift_d   = tx_shift_q;
    tx_bits_d    = tx_bits_q;
    tx_baud_d    = tx_baud_q;
    if (tx_bits_q != 4'd0) begin
      if (tx_baud_q == BAUD_LAST) begin
        tx_baud_d  = '0;
        tx_shift_d = {1'b1, tx_shift_q[9:1]};
        tx_bits_d  = tx_bits_q - 4'd1;
      end else begin
        tx_baud_d = tx_baud_q + BAUD_W'(1);
      end
    end else if (result_entry) begin
      tx_shift_d = {1'b1, tx_byte, 1'b0};
      tx_bits_d  = 4'd10;
      tx_baud_d  = '0;
    end
  end

  assign uart_tx = (tx_bits_q != 4'd0) ? tx_shift_q[0] : 1'b1;
`else
  // Keeps the baud parameters referenced when the UART is compiled out.
  localparam int BIT_CYC = CLK_HZ / BAUD;
  assign uart_tx = 1'b1 | (BIT_CYC == 0);
`endif

endmodule
